// File: rtl/ps2_key_fifo_pkg.sv
// Shared types and bit positions for the HPS ps2_key bus.
package input_pkg;

  localparam int PS2_TOGGLE  = 10;
  localparam int PS2_PRESSED = 9;
  localparam int PS2_EXT     = 8;

  typedef struct packed {
    logic       pressed;
    logic       extended;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_key_fifo_if.sv
// CPU-side pop/status bus of the key FIFO.
interface ps2_key_fifo_if #(
  parameter int DEPTH = 16
);
  import input_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic          rd;
  logic          clr;
  ps2_evt_t      dout;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          evt;

  modport master (
    output rd, clr,
    input  dout, empty, count, overflow, evt
  );

  modport slave (
    input  rd, clr,
    output dout, empty, count, overflow, evt
  );

endinterface

// File: rtl/ps2_key_fifo_fifo.sv
// Generic synchronous FIFO with flush; push and pop on a full FIFO both proceed.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             push_ok
);

  localparam logic [AW:0] MAX_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  // A pop frees the slot the simultaneous push needs, so full only blocks a lone push.
  always_comb begin
    empty   = (count == '0);
    do_pop  = pop && !empty && !rst && !clr;
    push_ok = push && ((count != MAX_COUNT) || do_pop) && !rst && !clr;
  end

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define validity,
  // which keeps the array mappable to LUTRAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_key_fifo.sv
// Turns each ps2_key[10] toggle into one queued key event for CPU polling.
module ps2_key_fifo
  import input_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic [10:0]  ps2_key,
  ps2_key_fifo_if.slave bus
);

  logic        tog_q;
  logic        push;
  logic        push_ok;
  logic        overflow;
  logic        evt;
  logic        empty;
  logic [AW:0] count;
  ps2_evt_t    entry;
  ps2_evt_t    head;

  assign push  = (ps2_key[PS2_TOGGLE] != tog_q);
  assign entry = '{pressed:  ps2_key[PS2_PRESSED],
                   extended: ps2_key[PS2_EXT],
                   code:     ps2_key[7:0]};

  sync_fifo #(
    .WIDTH ($bits(ps2_evt_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk_sys),
    .rst     (reset),
    .clr     (bus.clr),
    .push    (push),
    .pop     (bus.rd),
    .din     (entry),
    .dout    (head),
    .count   (count),
    .empty   (empty),
    .push_ok (push_ok)
  );

  // tog_q follows the bus even through reset and clr, so stale toggles never replay.
  // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[PS2_TOGGLE];
    if (reset) begin
      overflow <= 1'b0;
      evt      <= 1'b0;
    end else begin
      evt <= push_ok;
      if (bus.clr)
        overflow <= 1'b0;
      else if (push && !push_ok)
        overflow <= 1'b1;
    end
  end

  assign bus.dout     = empty ? ps2_evt_t'('0) : head;
  assign bus.empty    = empty;
  assign bus.count    = count;
  assign bus.overflow = overflow;
  assign bus.evt      = evt;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed self-checking bench for ps2_key_fifo (DEPTH = 16).
module tb_ps2_key_fifo;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = '0;
  logic        tog     = 1'b0;
  int          n_cmp   = 0;
  int          n_bad   = 0;

  ps2_key_fifo_if #(.DEPTH(16)) bus ();

  ps2_key_fifo #(.DEPTH(16)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_key (ps2_key),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic key_toggle(input logic pressed, input logic ext, input logic [7:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, ext, code};
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    bus.rd  = 1'b0;
    bus.clr = 1'b0;
    @(negedge clk_sys);
    tog     = 1'b1;
    ps2_key = {1'b1, 10'h000};
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    n_cmp++; if (bus.count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.dout !== 10'h000) begin n_bad++; $display("FAIL reset_dout: got %h want 000", bus.dout); end
    n_cmp++; if (bus.evt !== 1'b0) begin n_bad++; $display("FAIL reset_evt: got %b want 0", bus.evt); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
  endtask

  task automatic test_single;
    key_toggle(1'b1, 1'b0, 8'h1C);
    @(negedge clk_sys);
    n_cmp++; if (bus.count !== 5'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", bus.count); end
    n_cmp++; if (bus.dout !== 10'h21C) begin n_bad++; $display("FAIL single_dout: got %h want 21c", bus.dout); end
    n_cmp++; if (bus.evt !== 1'b1) begin n_bad++; $display("FAIL single_evt_high: got %b want 1", bus.evt); end
    @(negedge clk_sys);
    n_cmp++; if (bus.evt !== 1'b0) begin n_bad++; $display("FAIL single_evt_low: got %b want 0", bus.evt); end
    n_cmp++; if (bus.count !== 5'd1) begin n_bad++; $display("FAIL single_hold: got %0d want 1", bus.count); end
    bus.rd = 1'b1;
    @(negedge clk_sys);
    bus.rd = 1'b0;
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL single_pop_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.dout !== 10'h000) begin n_bad++; $display("FAIL single_pop_dout: got %h want 000", bus.dout); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 16; i++) begin
      key_toggle(1'b0, 1'b0, 8'(i));
      @(negedge clk_sys);
    end
    n_cmp++; if (bus.count !== 5'd16) begin n_bad++; $display("FAIL ovf_fill_count: got %0d want 16", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_not_yet: got %b want 0", bus.overflow); end
    key_toggle(1'b0, 1'b0, 8'h55);
    @(negedge clk_sys);
    n_cmp++; if (bus.count !== 5'd16) begin n_bad++; $display("FAIL ovf_count: got %0d want 16", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    n_cmp++; if (bus.evt !== 1'b0) begin n_bad++; $display("FAIL ovf_evt: got %b want 0", bus.evt); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (bus.dout !== 10'(i)) begin n_bad++; $display("FAIL ovf_pop_%0d: got %h want %h", i, bus.dout, 10'(i)); end
      bus.rd = 1'b1;
      @(negedge clk_sys);
    end
    bus.rd = 1'b0;
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL ovf_drained: got %b want 1", bus.empty); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    bus.clr = 1'b1;
    @(negedge clk_sys);
    bus.clr = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %b want 0", bus.overflow); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 16; i++) begin
      key_toggle(1'b0, 1'b0, 8'h30 + 8'(i));
      @(negedge clk_sys);
    end
    key_toggle(1'b1, 1'b1, 8'hAA);
    bus.rd = 1'b1;
    @(negedge clk_sys);
    bus.rd = 1'b0;
    n_cmp++; if (bus.count !== 5'd16) begin n_bad++; $display("FAIL full_pp_count: got %0d want 16", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL full_pp_overflow: got %b want 0", bus.overflow); end
    n_cmp++; if (bus.evt !== 1'b1) begin n_bad++; $display("FAIL full_pp_evt: got %b want 1", bus.evt); end
    n_cmp++; if (bus.dout !== 10'h031) begin n_bad++; $display("FAIL full_pp_head: got %h want 031", bus.dout); end
    bus.rd = 1'b1;
    repeat (15) @(negedge clk_sys);
    bus.rd = 1'b0;
    n_cmp++; if (bus.count !== 5'd1) begin n_bad++; $display("FAIL full_pp_tail_count: got %0d want 1", bus.count); end
    n_cmp++; if (bus.dout !== 10'h3AA) begin n_bad++; $display("FAIL full_pp_tail: got %h want 3aa", bus.dout); end
    bus.rd = 1'b1;
    @(negedge clk_sys);
    bus.rd = 1'b0;
  endtask

  task automatic test_clr_push;
    for (int i = 0; i < 5; i++) begin
      key_toggle(1'b1, 1'b0, 8'h40 + 8'(i));
      @(negedge clk_sys);
    end
    n_cmp++; if (bus.count !== 5'd5) begin n_bad++; $display("FAIL clr_pre_count: got %0d want 5", bus.count); end
    key_toggle(1'b1, 1'b0, 8'h66);
    bus.clr = 1'b1;
    @(negedge clk_sys);
    bus.clr = 1'b0;
    n_cmp++; if (bus.count !== 5'd0) begin n_bad++; $display("FAIL clr_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL clr_overflow: got %b want 0", bus.overflow); end
    n_cmp++; if (bus.evt !== 1'b0) begin n_bad++; $display("FAIL clr_evt: got %b want 0", bus.evt); end
    @(negedge clk_sys);
    n_cmp++; if (bus.count !== 5'd0) begin n_bad++; $display("FAIL clr_no_replay: got %0d want 0", bus.count); end
    n_cmp++; if (bus.dout !== 10'h000) begin n_bad++; $display("FAIL clr_dout: got %h want 000", bus.dout); end
  endtask

  task automatic test_pop_empty;
    bus.rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      n_cmp++; if (bus.count !== 5'd0) begin n_bad++; $display("FAIL empty_pop_%0d: got %0d want 0", i, bus.count); end
    end
    bus.rd = 1'b0;
    key_toggle(1'b0, 1'b1, 8'h7E);
    @(negedge clk_sys);
    n_cmp++; if (bus.dout !== 10'h17E) begin n_bad++; $display("FAIL empty_after_dout: got %h want 17e", bus.dout); end
    n_cmp++; if (bus.count !== 5'd1) begin n_bad++; $display("FAIL empty_after_count: got %0d want 1", bus.count); end
  endtask

  task automatic test_back_to_back;
    // count == 1: push and pop together keep count, head becomes the new entry
    key_toggle(1'b1, 1'b1, 8'h12);
    bus.rd = 1'b1;
    @(negedge clk_sys);
    n_cmp++; if (bus.count !== 5'd1) begin n_bad++; $display("FAIL b2b_mid_count: got %0d want 1", bus.count); end
    n_cmp++; if (bus.dout !== 10'h312) begin n_bad++; $display("FAIL b2b_mid_dout: got %h want 312", bus.dout); end
    @(negedge clk_sys);
    bus.rd = 1'b0;
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL b2b_drained: got %b want 1", bus.empty); end
    // empty: push and pop together, only the push takes effect
    key_toggle(1'b0, 1'b0, 8'h5A);
    bus.rd = 1'b1;
    @(negedge clk_sys);
    bus.rd = 1'b0;
    n_cmp++; if (bus.count !== 5'd1) begin n_bad++; $display("FAIL b2b_empty_count: got %0d want 1", bus.count); end
    n_cmp++; if (bus.dout !== 10'h05A) begin n_bad++; $display("FAIL b2b_empty_dout: got %h want 05a", bus.dout); end
    n_cmp++; if (bus.evt !== 1'b1) begin n_bad++; $display("FAIL b2b_empty_evt: got %b want 1", bus.evt); end
  endtask

  initial begin
    bus.rd  = 1'b0;
    bus.clr = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_clr_push();
    test_pop_empty();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
